// File: rtl/link_pkg.sv
// Shared types and defaults for the link receive path.
package link_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        CHECK   = 1'b1
    } rx_state_e;

    localparam int unsigned LINK_FRAME_BYTES_DEF = 4;

endpackage : link_pkg

// File: rtl/link_fifo.sv
// Small synchronous FIFO with registered full/empty flags; the head word reads
// as zero while the FIFO is empty.
module link_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule : link_fifo

// File: rtl/link_rx_packer.sv
// Packs received link bytes into little-endian words and buffers them in a FIFO.
// Define LINK_CSUM_EN to require a trailing XOR checksum byte per frame.
module link_rx_packer
    import link_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = LINK_FRAME_BYTES_DEF,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [8*FRAME_BYTES-1:0] out_data,
    input  logic                     out_ready,
    output logic [7:0]               frame_count
`ifdef LINK_CSUM_EN
    ,
    output logic                     csum_err
`endif
);

    localparam int unsigned IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    rx_state_e                state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [8*FRAME_BYTES-1:0] asm_q, asm_d;
    logic [8*FRAME_BYTES-1:0] word_ins;
    logic [8*FRAME_BYTES-1:0] push_word;
    logic                     accept;
    logic                     push;
    logic                     fifo_full;
    logic                     fifo_empty;
    byte_t                    in_byte;

    assign in_byte = in_data;
    assign accept  = in_valid && in_ready;

    // Assembly word with the incoming byte already merged, so the final data
    // byte can be pushed on the same edge that accepts it.
    always_comb begin
        word_ins = asm_q;
        word_ins[{idx_q, 3'b000} +: 8] = in_byte;
    end

`ifdef LINK_CSUM_EN
    byte_t xsum_q, xsum_d;
    logic  err_set;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        xsum_d    = xsum_q;
        push      = 1'b0;
        err_set   = 1'b0;
        push_word = asm_q;
        if (accept) begin
            case (state_q)
                COLLECT: begin
                    asm_d  = word_ins;
                    xsum_d = ((idx_q == '0) ? 8'h00 : xsum_q) ^ in_byte;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (in_byte == xsum_q) push = 1'b1;
                    else                   err_set = 1'b1;
                    idx_d   = '0;
                    state_d = COLLECT;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xsum_q   <= '0;
            csum_err <= 1'b0;
        end else begin
            xsum_q <= xsum_d;
            if (err_set) csum_err <= 1'b1;
        end
    end
`else
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        push      = 1'b0;
        push_word = word_ins;
        if (accept) begin
            case (state_q)
                COLLECT: begin
                    asm_d = word_ins;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        push  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            asm_q       <= '0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            if (push) frame_count <= frame_count + 1'b1;
        end
    end

    link_fifo #(
        .WIDTH (8*FRAME_BYTES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;

endmodule : link_rx_packer

// File: tb/tb_link_rx_packer.sv
// Self-checking bench for link_rx_packer against a queue-based frame model.
module tb_link_rx_packer;

    localparam int unsigned FB    = 4;
    localparam int unsigned DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              out_valid;
    logic [8*FB-1:0]   out_data;
    logic              out_ready;
    logic [7:0]        frame_count;
`ifdef LINK_CSUM_EN
    logic              csum_err;
`endif

    always #5 clk = ~clk;

    link_rx_packer #(
        .FRAME_BYTES (FB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .frame_count (frame_count)
`ifdef LINK_CSUM_EN
        ,
        .csum_err    (csum_err)
`endif
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: buffered words, bytes of the frame in progress, counters.
    logic [8*FB-1:0] expq[$];
    logic [7:0]      part[$];
    logic [7:0]      m_fc;
    logic            m_err;
    int unsigned     pops;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        part.delete();
        m_fc  = 8'd0;
        m_err = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        logic [8*FB-1:0] w;
        logic [7:0]      x;
        part.push_back(d);
`ifdef LINK_CSUM_EN
        if (part.size() == FB + 1) begin
            w = '0;
            x = 8'h00;
            for (int k = 0; k < FB; k++) begin
                w[8*k +: 8] = part[k];
                x = x ^ part[k];
            end
            if (x == part[FB]) begin
                expq.push_back(w);
                m_fc = m_fc + 8'd1;
            end else begin
                m_err = 1'b1;
            end
            part.delete();
        end
`else
        if (part.size() == FB) begin
            w = '0;
            for (int k = 0; k < FB; k++) w[8*k +: 8] = part[k];
            expq.push_back(w);
            m_fc = m_fc + 8'd1;
            part.delete();
        end
`endif
    endtask

    task automatic check_outputs();
        check("in_ready", {63'd0, in_ready}, {63'd0, expq.size() < DEPTH});
        check("out_valid", {63'd0, out_valid}, {63'd0, expq.size() > 0});
        check("out_data", 64'(out_data), (expq.size() > 0) ? 64'(expq[0]) : 64'd0);
        check("frame_count", 64'(frame_count), 64'(m_fc));
`ifdef LINK_CSUM_EN
        check("csum_err", {63'd0, csum_err}, {63'd0, m_err});
`endif
    endtask

    // One clock: compare state, drive inputs, advance the model, return #1 after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output bit acc);
        bit pop;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc = v && (expq.size() < DEPTH);
        pop = r && (expq.size() > 0);
        if (pop) begin
            void'(expq.pop_front());
            pops++;
        end
        if (acc) model_byte(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        bit acc;
        step(1'b0, 8'h00, r, acc);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic r);
        bit acc;
        int unsigned n;
        n = 0;
        do begin
            step(1'b1, d, r, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=%0h expected=accepted", d);
        end
    endtask

    task automatic send_frame(input logic [8*FB-1:0] w, input logic r);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < FB; k++) begin
            send_byte(w[8*k +: 8], r);
            x = x ^ w[8*k +: 8];
        end
`ifdef LINK_CSUM_EN
        send_byte(x, r);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
`ifdef LINK_CSUM_EN
        check("rst_csum_err", {63'd0, csum_err}, 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned pops0;
        bit          acc;
        logic [8*FB-1:0] w1, w2;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        pops = 0;
        model_reset();
        do_reset();

        // Basic frame, out_ready high.
        send_frame(32'h44332211, 1'b1);
        check("basic_valid", {63'd0, out_valid}, 64'd1);
        check("basic_data", 64'(out_data), 64'h44332211);
        check("basic_count", 64'(frame_count), 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Back-pressure: two frames fill the FIFO, third stalls.
        send_frame(32'hA1A2A3A4, 1'b0);
        send_frame(32'hB1B2B3B4, 1'b0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC4, 1'b0, acc);
        check("full_in_ready_held", {63'd0, in_ready}, 64'd0);
        check("full_head", 64'(out_data), 64'hA1A2A3A4);
        send_frame(32'hC1C2C3C4, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drained", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a frame.
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        do_reset();
        send_frame(32'hDDCCBBAA, 1'b0);
        check("post_rst_data", 64'(out_data), 64'hDDCCBBAA);
        check("post_rst_count", 64'(frame_count), 64'd1);

        // Final-byte push coinciding with a pop: occupancy stays at one.
        w1 = 32'h0BADF00D;
        w2 = 32'h12345678;
        do_reset();
        send_frame(w1, 1'b0);
`ifdef LINK_CSUM_EN
        for (int k = 0; k < FB; k++) send_byte(w2[8*k +: 8], 1'b0);
        send_byte(w2[7:0] ^ w2[15:8] ^ w2[23:16] ^ w2[31:24], 1'b1);
`else
        for (int k = 0; k < FB - 1; k++) send_byte(w2[8*k +: 8], 1'b0);
        send_byte(w2[8*(FB-1) +: 8], 1'b1);
`endif
        idle(1'b0);
        check("pushpop_valid", {63'd0, out_valid}, 64'd1);
        check("pushpop_ready", {63'd0, in_ready}, 64'd1);
        check("pushpop_data", 64'(out_data), 64'(w2));
        idle(1'b1);
        idle(1'b1);

`ifdef LINK_CSUM_EN
        // Checksum good, then bad; error is sticky.
        do_reset();
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b0);
        send_byte(8'h0F, 1'b0);
        check("csum_ok_data", 64'(out_data), 64'h08040201);
        check("csum_ok_err", {63'd0, csum_err}, 64'd0);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h04, 1'b1); send_byte(8'h08, 1'b1);
        send_byte(8'h0E, 1'b1);
        check("csum_bad_err", {63'd0, csum_err}, 64'd1);
        check("csum_bad_count", 64'(frame_count), 64'd1);
        send_frame(32'h0A0B0C0D, 1'b1);
        check("csum_sticky", {63'd0, csum_err}, 64'd1);
        idle(1'b1);
        idle(1'b1);
`endif

        // 256 random frames with out_ready high: count wraps, nothing lost.
        do_reset();
        pops0 = pops;
        for (int f = 0; f < 256; f++) begin
            send_frame($urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(1'b1);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("wrap_count", 64'(frame_count), 64'd0);
        check("wrap_delivered", 64'(pops - pops0), 64'd256);

        // Random traffic with back-pressure and ignored strobes.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("final_empty", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_link_rx_packer
